// File: rtl/x_byte_ser_pkg.sv
// Shared types and constants for the x_byte_ser word-to-byte serialiser.
// The optional checksum beat is controlled by X_BYTE_SER_CHECKSUM_EN.
package x_byte_ser_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        CHK
    } x_byte_ser_state_t;

endpackage

// File: rtl/x_byte_ser.sv
// Serialises an NBYTES-wide word into LSB-first byte beats over valid/accept handshakes.
// Defining X_BYTE_SER_CHECKSUM_EN appends one XOR checksum beat after each word.
module x_byte_ser
    import x_byte_ser_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    output logic                     o_accept,
    input  logic [BYTE_W*NBYTES-1:0] i_data,
    output logic                     o_valid,
    output logic [BYTE_W-1:0]        o_data,
    input  logic                     i_accept,
    output logic                     o_busy
);

    localparam int unsigned DATA_W = BYTE_W * NBYTES;
    localparam int unsigned CNT_W  = $clog2(NBYTES + 1);

    x_byte_ser_state_t state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept_q;
    logic              valid_q;
    logic [BYTE_W-1:0] data_q;
    logic              busy_q;
`ifdef X_BYTE_SER_CHECKSUM_EN
    logic [BYTE_W-1:0] xor_q;
`endif

    logic [DATA_W-1:0] shreg_shift;
    logic              last_beat;

    assign shreg_shift = shreg_q >> BYTE_W;
    assign last_beat   = (cnt_q == '0);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            accept_q <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            busy_q   <= 1'b0;
`ifdef X_BYTE_SER_CHECKSUM_EN
            xor_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_q && i_valid) begin
                        shreg_q  <= i_data;
                        cnt_q    <= CNT_W'(NBYTES - 1);
                        accept_q <= 1'b0;
                        valid_q  <= 1'b1;
                        data_q   <= i_data[BYTE_W-1:0];
                        busy_q   <= 1'b1;
                        state_q  <= SEND;
`ifdef X_BYTE_SER_CHECKSUM_EN
                        xor_q    <= '0;
`endif
                    end else begin
                        accept_q <= 1'b1;
                    end
                end
                SEND: begin
                    // data_q already mirrors shreg_q[7:0]; only advance on a taken beat.
                    if (i_accept) begin
                        shreg_q <= shreg_shift;
                        if (last_beat) begin
`ifdef X_BYTE_SER_CHECKSUM_EN
                            data_q  <= xor_q ^ data_q;
                            xor_q   <= xor_q ^ data_q;
                            state_q <= CHK;
`else
                            valid_q  <= 1'b0;
                            accept_q <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= IDLE;
`endif
                        end else begin
                            cnt_q  <= cnt_q - CNT_W'(1);
                            data_q <= shreg_shift[BYTE_W-1:0];
`ifdef X_BYTE_SER_CHECKSUM_EN
                            xor_q  <= xor_q ^ data_q;
`endif
                        end
                    end
                end
`ifdef X_BYTE_SER_CHECKSUM_EN
                CHK: begin
                    if (i_accept) begin
                        valid_q  <= 1'b0;
                        accept_q <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
`endif
                default: begin
                    valid_q  <= 1'b0;
                    accept_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign o_accept = accept_q;
    assign o_valid  = valid_q;
    assign o_data   = data_q;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_x_byte_ser.sv
// Directed bench for x_byte_ser: NBYTES=4 and NBYTES=1 instances, immediate-assertion checks.
// Expectations include the checksum beat when X_BYTE_SER_CHECKSUM_EN is defined.
module tb_x_byte_ser;

    logic        clk;
    logic        rst_n;

    logic        v0;
    logic        acc0;
    logic [31:0] d0;
    logic        ov0;
    logic [7:0]  od0;
    logic        a0;
    logic        busy0;

    logic        v1;
    logic        acc1;
    logic [7:0]  d1;
    logic        ov1;
    logic [7:0]  od1;
    logic        a1;
    logic        busy1;

    int n_cmp = 0;
    int n_err = 0;

    x_byte_ser #(.NBYTES(4)) u_dut4 (
        .i_clk    (clk),
        .i_rst    (rst_n),
        .i_valid  (v0),
        .o_accept (acc0),
        .i_data   (d0),
        .o_valid  (ov0),
        .o_data   (od0),
        .i_accept (a0),
        .o_busy   (busy0)
    );

    x_byte_ser #(.NBYTES(1)) u_dut1 (
        .i_clk    (clk),
        .i_rst    (rst_n),
        .i_valid  (v1),
        .o_accept (acc1),
        .i_data   (d1),
        .o_valid  (ov1),
        .o_data   (od1),
        .i_accept (a1),
        .o_busy   (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic beat4(input string tag, input logic [7:0] exp);
        chk({tag, ".valid"}, {31'd0, ov0}, 32'd1);
        chk({tag, ".data"}, {24'd0, od0}, {24'd0, exp});
    endtask

    task automatic idle4(input string tag);
        chk({tag, ".valid"}, {31'd0, ov0}, 32'd0);
        chk({tag, ".accept"}, {31'd0, acc0}, 32'd1);
        chk({tag, ".busy"}, {31'd0, busy0}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        v0 = 1'b0; a0 = 1'b0; d0 = '0;
        v1 = 1'b0; a1 = 1'b1; d1 = '0;

        // Reset state
        tick();
        tick();
        chk("rst.accept", {31'd0, acc0}, 32'd0);
        chk("rst.valid", {31'd0, ov0}, 32'd0);
        chk("rst.data", {24'd0, od0}, 32'd0);
        chk("rst.busy", {31'd0, busy0}, 32'd0);
        rst_n = 1'b1;
        #2;
        chk("rel.accept_low", {31'd0, acc0}, 32'd0);
        tick();
        chk("rel.accept_high", {31'd0, acc0}, 32'd1);
        chk("rel.accept1_high", {31'd0, acc1}, 32'd1);

        // Test 1: streaming with sink always ready
        v0 = 1'b1; d0 = 32'hDDCCBBAA; a0 = 1'b1;
        tick();
        v0 = 1'b0;
        beat4("t1.b0", 8'hAA);
        chk("t1.accept_low", {31'd0, acc0}, 32'd0);
        chk("t1.busy", {31'd0, busy0}, 32'd1);
        tick(); beat4("t1.b1", 8'hBB);
        tick(); beat4("t1.b2", 8'hCC);
        tick(); beat4("t1.b3", 8'hDD);
`ifdef X_BYTE_SER_CHECKSUM_EN
        tick(); beat4("t1.chk", 8'h00);
`endif
        tick(); idle4("t1.end");

        // Test 2: sink stalls for three cycles on byte0
        v0 = 1'b1; d0 = 32'hDDCCBBAA; a0 = 1'b0;
        tick();
        v0 = 1'b0;
        beat4("t2.hold0", 8'hAA);
        tick(); beat4("t2.hold1", 8'hAA);
        tick(); beat4("t2.hold2", 8'hAA);
        a0 = 1'b1;
        tick(); beat4("t2.b1", 8'hBB);
        tick(); beat4("t2.b2", 8'hCC);
        tick(); beat4("t2.b3", 8'hDD);
`ifdef X_BYTE_SER_CHECKSUM_EN
        tick(); beat4("t2.chk", 8'h00);
`endif
        tick(); idle4("t2.end");

        // Test 3: back-to-back words with i_valid held
        v0 = 1'b1; d0 = 32'h44332211; a0 = 1'b1;
        tick(); beat4("t3.w0b0", 8'h11);
        d0 = 32'h88776655;
        tick(); beat4("t3.w0b1", 8'h22);
        tick(); beat4("t3.w0b2", 8'h33);
        tick(); beat4("t3.w0b3", 8'h44);
`ifdef X_BYTE_SER_CHECKSUM_EN
        tick(); beat4("t3.w0chk", 8'h44);
`endif
        tick(); idle4("t3.bubble");
        tick(); beat4("t3.w1b0", 8'h55);
        v0 = 1'b0;
        tick(); beat4("t3.w1b1", 8'h66);
        tick(); beat4("t3.w1b2", 8'h77);
        tick(); beat4("t3.w1b3", 8'h88);
`ifdef X_BYTE_SER_CHECKSUM_EN
        tick(); beat4("t3.w1chk", 8'hCC);
`endif
        tick(); idle4("t3.end");

        // Test 4: reset mid-word discards the partial word
        v0 = 1'b1; d0 = 32'hDDCCBBAA; a0 = 1'b1;
        tick(); beat4("t4.b0", 8'hAA);
        v0 = 1'b0;
        tick(); beat4("t4.b1", 8'hBB);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4.rst_valid", {31'd0, ov0}, 32'd0);
        chk("t4.rst_busy", {31'd0, busy0}, 32'd0);
        chk("t4.rst_accept", {31'd0, acc0}, 32'd0);
        tick();
        chk("t4.rst_hold_accept", {31'd0, acc0}, 32'd0);
        rst_n = 1'b1;
        #2;
        chk("t4.rel_accept", {31'd0, acc0}, 32'd0);
        tick();
        chk("t4.rel_accept_high", {31'd0, acc0}, 32'd1);
        v0 = 1'b1; d0 = 32'h04030201;
        tick(); beat4("t4.n0", 8'h01);
        v0 = 1'b0;
        tick(); beat4("t4.n1", 8'h02);
        tick(); beat4("t4.n2", 8'h03);
        tick(); beat4("t4.n3", 8'h04);
`ifdef X_BYTE_SER_CHECKSUM_EN
        // Test 5: checksum beat 01^02^03^04
        tick(); beat4("t5.chk", 8'h04);
`endif
        tick(); idle4("t4.end");

        // Test 6: NBYTES=1 with i_valid held gives one idle cycle between beats
        v1 = 1'b1; d1 = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("t6.b%0d.valid", k), {31'd0, ov1}, 32'd1);
            chk($sformatf("t6.b%0d.data", k), {24'd0, od1}, 32'h5A);
            chk($sformatf("t6.b%0d.accept", k), {31'd0, acc1}, 32'd0);
`ifdef X_BYTE_SER_CHECKSUM_EN
            tick();
            chk($sformatf("t6.c%0d.data", k), {24'd0, od1}, 32'h5A);
`endif
            tick();
            chk($sformatf("t6.gap%0d.valid", k), {31'd0, ov1}, 32'd0);
            chk($sformatf("t6.gap%0d.accept", k), {31'd0, acc1}, 32'd1);
        end
        v1 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
